// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control sequencer.
// Sequences fetch/decode/execute/memory/writeback. It drives the ALU control and
// operand-select lines and resolves beq from the ALU zero flag. Memory accesses
// wait on i_mem_ready, with an optional timeout into a sticky HALT state.
// Optional feature macro: ILLEGAL_TRAP_EN. When it is defined, an illegal opcode
// or funct traps and raises o_illegal. When it is undefined, an illegal opcode
// or funct behaves as a NOP.
module mips_mc_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic       i_zf,
    input  logic       i_mem_ready,
    output logic [3:0] o_alu_control,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_pc_source,
    output logic       o_pc_en,
    output logic       o_ir_write,
    output logic       o_iord,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_reg_write,
    output logic       o_reg_dst,
    output logic       o_mem_to_reg,
    output logic [3:0] o_state,
`ifdef ILLEGAL_TRAP_EN
    output logic       o_illegal,
`endif
    output logic       o_bus_err
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC   = 4'd7,
        S_RWB    = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_BEQ    = 4'd11,
        S_JUMP   = 4'd12, S_HALT   = 4'd13, S_TRAP   = 4'd14
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010,
                           ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_NOR = 4'b1100;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);
    localparam bit TIMEOUT_ON = (MEM_TIMEOUT != 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
`ifdef ILLEGAL_TRAP_EN
    logic             illegal_q, illegal_d;
`endif
    logic             funct_ok;
    logic [3:0]       funct_alu;
    logic             mem_wait;
    logic             mem_timeout;

    // Map an R-type funct field to its ALU code; bit 4 flags a legal funct.
    function automatic logic [4:0] decode_funct(input logic [5:0] funct);
        case (funct)
            6'b100000: decode_funct = {1'b1, ALU_ADD};
            6'b100010: decode_funct = {1'b1, ALU_SUB};
            6'b100100: decode_funct = {1'b1, ALU_AND};
            6'b100101: decode_funct = {1'b1, ALU_OR};
            6'b101010: decode_funct = {1'b1, ALU_SLT};
            6'b100111: decode_funct = {1'b1, ALU_NOR};
            default:   decode_funct = {1'b0, ALU_AND};
        endcase
    endfunction

    // Wait-state bookkeeping shared by FETCH, MEMRD and MEMWR.
    always_comb begin
        {funct_ok, funct_alu} = decode_funct(i_funct);
        mem_wait    = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        cnt_d       = '0;
        mem_timeout = 1'b0;
        if (mem_wait && !i_mem_ready) begin
            cnt_d       = cnt_q + CNT_W'(1);
            mem_timeout = TIMEOUT_ON && (cnt_d == TIMEOUT_CNT);
        end
    end

    // Next-state selection and sticky error flags.
    always_comb begin
        state_d   = state_q;
        bus_err_d = bus_err_q;
`ifdef ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (i_mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (i_opcode)
                    6'b000000:            state_d = S_EXEC;
                    6'b100011, 6'b101011: state_d = S_MEMADR;
                    6'b000100:            state_d = S_BEQ;
                    6'b001000:            state_d = S_ADDIEX;
                    6'b000010:            state_d = S_JUMP;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
`else
                        state_d   = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR: state_d = (i_opcode == 6'b101011) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (i_mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (i_mem_ready) state_d = S_FETCH;
            S_EXEC: begin
                if (funct_ok) begin
                    state_d = S_RWB;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
`else
                    state_d   = S_FETCH;
`endif
                end
            end
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_RWB, S_ADDIWB, S_BEQ, S_JUMP: state_d = S_FETCH;
            S_HALT, S_TRAP: state_d = state_q;
            default:  state_d = S_IDLE;
        endcase
        if (mem_timeout) begin
            state_d   = S_HALT;
            bus_err_d = 1'b1;
        end
    end

    // State, wait counter and sticky flags; reset drops everything at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    // Control outputs decoded from the current state. The handshake and zero flag
    // terms stay combinational so that PC/IR updates land in the completing cycle.
    always_comb begin
        o_alu_control = ALU_AND;
        o_alu_src_a   = 1'b0;
        o_alu_src_b   = 2'b00;
        o_pc_source   = 2'b00;
        o_pc_en       = 1'b0;
        o_ir_write    = 1'b0;
        o_iord        = 1'b0;
        o_mem_read    = 1'b0;
        o_mem_write   = 1'b0;
        o_reg_write   = 1'b0;
        o_reg_dst     = 1'b0;
        o_mem_to_reg  = 1'b0;
        case (state_q)
            S_FETCH: begin
                o_mem_read    = 1'b1;
                o_alu_src_b   = 2'b01;
                o_alu_control = ALU_ADD;
                o_ir_write    = i_mem_ready;
                o_pc_en       = i_mem_ready;
            end
            S_DECODE: begin
                o_alu_src_b   = 2'b11;
                o_alu_control = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                o_alu_src_a   = 1'b1;
                o_alu_src_b   = 2'b10;
                o_alu_control = ALU_ADD;
            end
            S_MEMRD: begin
                o_mem_read = 1'b1;
                o_iord     = 1'b1;
            end
            S_MEMWB: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                o_mem_write = 1'b1;
                o_iord      = 1'b1;
            end
            S_EXEC: begin
                o_alu_src_a   = 1'b1;
                o_alu_control = funct_alu;
            end
            S_RWB: begin
                o_reg_write = 1'b1;
                o_reg_dst   = 1'b1;
            end
            S_ADDIWB: o_reg_write = 1'b1;
            S_BEQ: begin
                o_alu_src_a   = 1'b1;
                o_alu_control = ALU_SUB;
                o_pc_source   = 2'b01;
                o_pc_en       = i_zf;
            end
            S_JUMP: begin
                o_pc_source = 2'b10;
                o_pc_en     = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_state   = state_q;
    assign o_bus_err = bus_err_q;
`ifdef ILLEGAL_TRAP_EN
    assign o_illegal = illegal_q;
`endif

endmodule
